// File: rtl/aes_key_queue.sv
// aes_key_queue
// Fixed-latency shift-register queue of 128-bit AES round-key words, sitting
// between the key source and the round datapath. Every clock edge one word
// enters the tail and every stored word moves one stage toward the head.
//
// Ports
//   clock     : rising-edge clock
//   reset_n   : synchronous active-low reset
//   in        : 128-bit word written into the tail every cycle (byte 0 = [127:120])
//   K0..KF    : head word bytes (stage DEPTH-1), K0 = head[127:120]
//   G0..GF    : next-oldest word bytes (stage DEPTH-2), same byte order
//   Rcon_out  : AES round constant paired with the head word
//   empty     : 1 while the head stage holds no valid word
module aes_key_queue #(
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [127:0] in,
    output logic [7:0]   K0,
    output logic [7:0]   K1,
    output logic [7:0]   K2,
    output logic [7:0]   K3,
    output logic [7:0]   K4,
    output logic [7:0]   K5,
    output logic [7:0]   K6,
    output logic [7:0]   K7,
    output logic [7:0]   K8,
    output logic [7:0]   K9,
    output logic [7:0]   KA,
    output logic [7:0]   KB,
    output logic [7:0]   KC,
    output logic [7:0]   KD,
    output logic [7:0]   KE,
    output logic [7:0]   KF,
    output logic [7:0]   G0,
    output logic [7:0]   G1,
    output logic [7:0]   G2,
    output logic [7:0]   G3,
    output logic [7:0]   G4,
    output logic [7:0]   G5,
    output logic [7:0]   G6,
    output logic [7:0]   G7,
    output logic [7:0]   G8,
    output logic [7:0]   G9,
    output logic [7:0]   GA,
    output logic [7:0]   GB,
    output logic [7:0]   GC,
    output logic [7:0]   GD,
    output logic [7:0]   GE,
    output logic [7:0]   GF,
    output logic [7:0]   Rcon_out,
    output logic         empty
);

    logic [127:0]     stage_q [DEPTH];
    logic [127:0]     stage_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [3:0]       rcon_idx_q;
    logic [3:0]       rcon_idx_d;

    logic [127:0]     head;
    logic [127:0]     next_word;
    logic [7:0]       rcon_lut;

    always_comb begin
        stage_d[0] = in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        valid_d = {valid_q[DEPTH-2:0], 1'b1};

        // The index sits at 0 until the head has been valid for one edge, so
        // the first valid head is paired with 0x01; it then steps every edge.
        if (valid_q[DEPTH-1]) begin
            rcon_idx_d = (rcon_idx_q == 4'd9) ? 4'd0 : rcon_idx_q + 4'd1;
        end else begin
            rcon_idx_d = 4'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            valid_q    <= '0;
            rcon_idx_q <= 4'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            valid_q    <= valid_d;
            rcon_idx_q <= rcon_idx_d;
        end
    end

    always_comb begin
        case (rcon_idx_q)
            4'd0:    rcon_lut = 8'h01;
            4'd1:    rcon_lut = 8'h02;
            4'd2:    rcon_lut = 8'h04;
            4'd3:    rcon_lut = 8'h08;
            4'd4:    rcon_lut = 8'h10;
            4'd5:    rcon_lut = 8'h20;
            4'd6:    rcon_lut = 8'h40;
            4'd7:    rcon_lut = 8'h80;
            4'd8:    rcon_lut = 8'h1B;
            4'd9:    rcon_lut = 8'h36;
            default: rcon_lut = 8'h00;
        endcase
    end

    assign empty    = ~valid_q[DEPTH-1];
    assign Rcon_out = empty ? 8'h00 : rcon_lut;

    assign head = stage_q[DEPTH-1];
    // Masked by its valid bit so G reads zero until a real word arrives,
    // independent of the stage register's power-up contents.
    assign next_word = valid_q[DEPTH-2] ? stage_q[DEPTH-2] : 128'h0;

    assign K0 = head[127:120];
    assign K1 = head[119:112];
    assign K2 = head[111:104];
    assign K3 = head[103:96];
    assign K4 = head[95:88];
    assign K5 = head[87:80];
    assign K6 = head[79:72];
    assign K7 = head[71:64];
    assign K8 = head[63:56];
    assign K9 = head[55:48];
    assign KA = head[47:40];
    assign KB = head[39:32];
    assign KC = head[31:24];
    assign KD = head[23:16];
    assign KE = head[15:8];
    assign KF = head[7:0];

    assign G0 = next_word[127:120];
    assign G1 = next_word[119:112];
    assign G2 = next_word[111:104];
    assign G3 = next_word[103:96];
    assign G4 = next_word[95:88];
    assign G5 = next_word[87:80];
    assign G6 = next_word[79:72];
    assign G7 = next_word[71:64];
    assign G8 = next_word[63:56];
    assign G9 = next_word[55:48];
    assign GA = next_word[47:40];
    assign GB = next_word[39:32];
    assign GC = next_word[31:24];
    assign GD = next_word[23:16];
    assign GE = next_word[15:8];
    assign GF = next_word[7:0];

endmodule

// File: tb/tb_aes_key_queue.sv
module tb_aes_key_queue;

    localparam int DEPTH = 4;

    logic         clock;
    logic         reset_n;
    logic [127:0] in_w;
    logic [7:0]   K0, K1, K2, K3, K4, K5, K6, K7, K8, K9, KA, KB, KC, KD, KE, KF;
    logic [7:0]   G0, G1, G2, G3, G4, G5, G6, G7, G8, G9, GA, GB, GC, GD, GE, GF;
    logic [7:0]   Rcon_out;
    logic         empty;

    logic [127:0] k_word;
    logic [127:0] g_word;

    int tests_run;
    int tests_failed;

    // Every word accepted since the last reset, oldest first.
    logic [127:0] hist[$];

    aes_key_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .in(in_w),
        .K0(K0), .K1(K1), .K2(K2), .K3(K3), .K4(K4), .K5(K5), .K6(K6), .K7(K7),
        .K8(K8), .K9(K9), .KA(KA), .KB(KB), .KC(KC), .KD(KD), .KE(KE), .KF(KF),
        .G0(G0), .G1(G1), .G2(G2), .G3(G3), .G4(G4), .G5(G5), .G6(G6), .G7(G7),
        .G8(G8), .G9(G9), .GA(GA), .GB(GB), .GC(GC), .GD(GD), .GE(GE), .GF(GF),
        .Rcon_out(Rcon_out), .empty(empty)
    );

    assign k_word = {K0, K1, K2, K3, K4, K5, K6, K7, K8, K9, KA, KB, KC, KD, KE, KF};
    assign g_word = {G0, G1, G2, G3, G4, G5, G6, G7, G8, G9, GA, GB, GC, GD, GE, GF};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word whose byte j is (b*16 + j): mk(0) = 0x000102..0F, mk(1) = 0x1011..1F.
    function automatic logic [127:0] mk(input int b);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 16; j++) begin
            w[127-8*j -: 8] = 8'((b * 16 + j) & 8'hFF);
        end
        return w;
    endfunction

    function automatic logic [7:0] rcon_of(input int i);
        logic [7:0] r;
        r = 8'h01;
        for (int s = 0; s < i; s++) begin
            r = r[7] ? ((r << 1) ^ 8'h1B) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [127:0] m_k();
        int n;
        n = hist.size();
        if (n >= DEPTH) return hist[n-DEPTH];
        return 128'h0;
    endfunction

    function automatic logic [127:0] m_g();
        int n;
        n = hist.size();
        if (n >= DEPTH-1) return hist[n-DEPTH+1];
        return 128'h0;
    endfunction

    function automatic logic m_empty();
        return (hist.size() < DEPTH);
    endfunction

    function automatic logic [7:0] m_rcon();
        if (hist.size() < DEPTH) return 8'h00;
        return rcon_of((hist.size() - DEPTH) % 10);
    endfunction

    // One clock edge with the given reset level and input word; returns #1
    // after the edge so outputs are sampled away from it.
    task automatic step(input logic rst_lvl, input logic [127:0] d);
        reset_n = rst_lvl;
        in_w    = d;
        @(posedge clock);
        if (!rst_lvl) hist.delete();
        else          hist.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, {$urandom, $urandom, $urandom, $urandom});
        step(1'b0, {$urandom, $urandom, $urandom, $urandom});
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_empty: got %b want 1", empty);
        end
        tests_run++;
        if (Rcon_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_rcon: got %h want 00", Rcon_out);
        end
        tests_run++;
        if (k_word !== 128'h0 || g_word !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_kg: K=%h G=%h want zero", k_word, g_word);
        end
    endtask

    task automatic test_fill();
        step(1'b0, 128'h0);
        for (int w = 0; w < 4; w++) begin
            step(1'b1, mk(w));
            tests_run++;
            if (empty !== (w < 3)) begin
                tests_failed++;
                $display("FAIL fill_empty[%0d]: got %b want %b", w, empty, (w < 3));
            end
        end
        tests_run++;
        if (K0 !== 8'h00 || KF !== 8'h0F || G0 !== 8'h10 || GF !== 8'h1F) begin
            tests_failed++;
            $display("FAIL fill_bytes: K0=%h KF=%h G0=%h GF=%h want 00 0F 10 1F", K0, KF, G0, GF);
        end
        tests_run++;
        if (Rcon_out !== 8'h01) begin
            tests_failed++;
            $display("FAIL fill_rcon: got %h want 01", Rcon_out);
        end
    endtask

    task automatic test_advance();
        step(1'b1, mk(4));
        tests_run++;
        if (K0 !== 8'h10 || G0 !== 8'h20 || Rcon_out !== 8'h02) begin
            tests_failed++;
            $display("FAIL advance5: K0=%h G0=%h rcon=%h want 10 20 02", K0, G0, Rcon_out);
        end
        step(1'b1, mk(5));
        tests_run++;
        if (K0 !== 8'h20 || G0 !== 8'h30 || Rcon_out !== 8'h04) begin
            tests_failed++;
            $display("FAIL advance6: K0=%h G0=%h rcon=%h want 20 30 04", K0, G0, Rcon_out);
        end
        tests_run++;
        if (k_word !== mk(2) || g_word !== mk(3)) begin
            tests_failed++;
            $display("FAIL advance_words: K=%h G=%h want %h %h", k_word, g_word, mk(2), mk(3));
        end
    endtask

    task automatic test_rcon_wrap();
        logic [7:0] seq [11];
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36, 8'h01};
        step(1'b0, 128'h0);
        for (int w = 0; w < 3; w++) step(1'b1, {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 11; i++) begin
            step(1'b1, {$urandom, $urandom, $urandom, $urandom});
            tests_run++;
            if (Rcon_out !== seq[i] || empty !== 1'b0) begin
                tests_failed++;
                $display("FAIL rcon_wrap[%0d]: rcon=%h empty=%b want %h 0", i, Rcon_out, empty, seq[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int w = 0; w < 5; w++) step(1'b1, mk(8 + w));
        step(1'b0, mk(15));
        tests_run++;
        if (empty !== 1'b1 || k_word !== 128'h0 || g_word !== 128'h0 || Rcon_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset: empty=%b K=%h G=%h rcon=%h want 1 0 0 00",
                     empty, k_word, g_word, Rcon_out);
        end
        for (int w = 0; w < 4; w++) begin
            step(1'b1, mk(w));
            tests_run++;
            if (empty !== (w < 3) || g_word !== ((w >= 2) ? mk(w - 2) : 128'h0)) begin
                tests_failed++;
                $display("FAIL refill[%0d]: empty=%b G=%h want %b %h", w, empty, g_word,
                         (w < 3), (w >= 2) ? mk(w - 2) : 128'h0);
            end
        end
        tests_run++;
        if (k_word !== mk(0) || Rcon_out !== 8'h01) begin
            tests_failed++;
            $display("FAIL refill_head: K=%h rcon=%h want %h 01", k_word, Rcon_out, mk(0));
        end
    endtask

    task automatic test_byte_order();
        step(1'b0, 128'h0);
        step(1'b1, {8'hFF, 120'h0});
        step(1'b1, {120'h0, 8'hAA});
        step(1'b1, mk(7));
        step(1'b1, mk(9));
        tests_run++;
        if (K0 !== 8'hFF || k_word[119:0] !== 120'h0) begin
            tests_failed++;
            $display("FAIL byte_order_k: K=%h want ff000000000000000000000000000000", k_word);
        end
        tests_run++;
        if (GF !== 8'hAA || g_word[127:8] !== 120'h0) begin
            tests_failed++;
            $display("FAIL byte_order_g: G=%h want 000000000000000000000000000000aa", g_word);
        end
    endtask

    task automatic test_random();
        logic rst_lvl;
        for (int c = 0; c < 400; c++) begin
            rst_lvl = ($urandom_range(0, 39) != 0);
            step(rst_lvl, {$urandom, $urandom, $urandom, $urandom});
            tests_run++;
            if (k_word !== m_k() || g_word !== m_g() || empty !== m_empty() || Rcon_out !== m_rcon()) begin
                tests_failed++;
                $display("FAIL random[%0d]: K=%h G=%h empty=%b rcon=%h want %h %h %b %h",
                         c, k_word, g_word, empty, Rcon_out, m_k(), m_g(), m_empty(), m_rcon());
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        in_w         = 128'h0;
        test_reset();
        test_fill();
        test_advance();
        test_rcon_wrap();
        test_mid_reset();
        test_byte_order();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
